// File: rtl/risc16_mem_arb_if.sv
// Bus bundle joining the RISC16 fetch/data ports, the memory arbiter and the memory.
interface risc16_mem_arb_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic [AW-1:0] iaddr;
  logic          ioe;
  logic [DW-1:0] idin;
  logic          i_ready;

  logic [AW-1:0] daddr;
  logic          doe;
  logic          dwe0;
  logic          dwe1;
  logic [DW-1:0] ddout;
  logic [DW-1:0] ddin;
  logic          d_ready;

  logic [AW-1:0] maddr;
  logic          moe;
  logic          mwe0;
  logic          mwe1;
  logic [DW-1:0] mwdata;
  logic [DW-1:0] mrdata;

  modport master (
    output iaddr, ioe, daddr, doe, dwe0, dwe1, ddout, mrdata,
    input  idin, i_ready, ddin, d_ready, maddr, moe, mwe0, mwe1, mwdata
  );

  modport slave (
    input  iaddr, ioe, daddr, doe, dwe0, dwe1, ddout, mrdata,
    output idin, i_ready, ddin, d_ready, maddr, moe, mwe0, mwe1, mwdata
  );
endinterface

// File: rtl/risc16_mem_arb.sv
// Arbitrates the RISC16 fetch and data ports onto one single-ported, wait-stated memory.
module risc16_mem_arb #(
  parameter int unsigned WAIT_STATES = 1,
  parameter bit          FAIR        = 1'b1
) (
  input logic             clk,
  input logic             rst,
  risc16_mem_arb_if.slave bus
);
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_STATES);
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          last_d, last_d_n;
  logic          we0_q, we0_n, we1_q, we1_n;
  logic [AW-1:0] maddr_q, maddr_n;
  logic          moe_q, moe_n;
  logic          mwe0_q, mwe0_n, mwe1_q, mwe1_n;
  logic [DW-1:0] mwdata_q, mwdata_n;
  logic [DW-1:0] idin_q, idin_n, ddin_q, ddin_n;
  logic          i_rdy_q, i_rdy_n, d_rdy_q, d_rdy_n;
  logic          dreq, gnt_d, gnt_i;

  // Outputs are registered one cycle ahead so strobes/ready land in the final bus cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_d   <= 1'b0;
      we0_q    <= 1'b0;
      we1_q    <= 1'b0;
      maddr_q  <= '0;
      moe_q    <= 1'b0;
      mwe0_q   <= 1'b0;
      mwe1_q   <= 1'b0;
      mwdata_q <= '0;
      idin_q   <= '0;
      ddin_q   <= '0;
      i_rdy_q  <= 1'b0;
      d_rdy_q  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last_d   <= last_d_n;
      we0_q    <= we0_n;
      we1_q    <= we1_n;
      maddr_q  <= maddr_n;
      moe_q    <= moe_n;
      mwe0_q   <= mwe0_n;
      mwe1_q   <= mwe1_n;
      mwdata_q <= mwdata_n;
      idin_q   <= idin_n;
      ddin_q   <= ddin_n;
      i_rdy_q  <= i_rdy_n;
      d_rdy_q  <= d_rdy_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_d_n = last_d;
    we0_n    = we0_q;
    we1_n    = we1_q;
    maddr_n  = maddr_q;
    moe_n    = moe_q;
    mwdata_n = mwdata_q;
    idin_n   = idin_q;
    ddin_n   = ddin_q;
    mwe0_n   = 1'b0;
    mwe1_n   = 1'b0;
    i_rdy_n  = 1'b0;
    d_rdy_n  = 1'b0;
    dreq     = bus.doe | bus.dwe0 | bus.dwe1;
    gnt_d    = dreq && !(bus.ioe && FAIR && last_d);
    gnt_i    = bus.ioe && !gnt_d;

    case (state)
      IDLE: begin
        maddr_n  = '0;
        moe_n    = 1'b0;
        mwdata_n = '0;
        if (gnt_d) begin
          state_n  = BUSY_D;
          cnt_n    = CNT_INIT;
          last_d_n = 1'b1;
          maddr_n  = bus.daddr;
          mwdata_n = bus.ddout;
          we0_n    = bus.dwe0;
          we1_n    = bus.dwe1;
          moe_n    = !(bus.dwe0 | bus.dwe1);
          mwe0_n   = NO_WAIT & bus.dwe0;
          mwe1_n   = NO_WAIT & bus.dwe1;
          d_rdy_n  = NO_WAIT;
        end else if (gnt_i) begin
          state_n  = BUSY_I;
          cnt_n    = CNT_INIT;
          last_d_n = 1'b0;
          maddr_n  = bus.iaddr;
          we0_n    = 1'b0;
          we1_n    = 1'b0;
          moe_n    = 1'b1;
          i_rdy_n  = NO_WAIT;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            mwe0_n  = we0_q;
            mwe1_n  = we1_q;
            i_rdy_n = (state == BUSY_I);
            d_rdy_n = (state == BUSY_D);
          end
        end else begin
          // Final cycle: capture read data, drop the bus, force an IDLE turnaround.
          state_n  = IDLE;
          maddr_n  = '0;
          moe_n    = 1'b0;
          mwdata_n = '0;
          if (state == BUSY_I) idin_n = bus.mrdata;
          else if (moe_q)      ddin_n = bus.mrdata;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.maddr   = maddr_q;
  assign bus.moe     = moe_q;
  assign bus.mwe0    = mwe0_q;
  assign bus.mwe1    = mwe1_q;
  assign bus.mwdata  = mwdata_q;
  assign bus.idin    = idin_q;
  assign bus.ddin    = ddin_q;
  assign bus.i_ready = i_rdy_q;
  assign bus.d_ready = d_rdy_q;
endmodule

// File: tb/tb_risc16_mem_arb.sv
// Bench for risc16_mem_arb: two instances (1 wait/fair, 0 wait/data-priority) against a timeline model.
module tb_risc16_mem_arb;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  risc16_mem_arb_if bus_a ();
  risc16_mem_arb_if bus_b ();

  risc16_mem_arb #(.WAIT_STATES(1), .FAIR(1'b1)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  risc16_mem_arb #(.WAIT_STATES(0), .FAIR(1'b0)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  logic [7:0]  mem_a [65536];
  logic [7:0]  mem_b [65536];
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;

  localparam logic [15:0] PA [14] = '{16'h0010, 16'h0011, 16'h0020, 16'h0021, 16'hC000, 16'hC001, 16'h0200,
                                      16'h0201, 16'h0040, 16'h0041, 16'h0042, 16'h0043, 16'hFFFE, 16'hFFFF};
  localparam logic [7:0]  PD [14] = '{8'h12, 8'h34, 8'hA5, 8'h5A, 8'h77, 8'h11, 8'h99,
                                      8'h66, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h5C, 8'h3E};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus_a.mrdata = {mem_a[{bus_a.maddr[15:1], 1'b0}], mem_a[{bus_a.maddr[15:1], 1'b1}]};
  assign bus_b.mrdata = {mem_b[{bus_b.maddr[15:1], 1'b0}], mem_b[{bus_b.maddr[15:1], 1'b1}]};

  always @(posedge clk) begin
    if (pre_we) begin
      mem_a[pre_addr] <= pre_data;
      mem_b[pre_addr] <= pre_data;
    end
    if (bus_a.mwe0) mem_a[{bus_a.maddr[15:1], 1'b0}] <= bus_a.mwdata[15:8];
    if (bus_a.mwe1) mem_a[{bus_a.maddr[15:1], 1'b1}] <= bus_a.mwdata[7:0];
    if (bus_b.mwe0) mem_b[{bus_b.maddr[15:1], 1'b0}] <= bus_b.mwdata[15:8];
    if (bus_b.mwe1) mem_b[{bus_b.maddr[15:1], 1'b1}] <= bus_b.mwdata[7:0];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model: one granted access occupies cycles gcyc+1 .. gcyc+1+w.
  typedef struct {
    bit          active;
    bit          port_d;
    bit          rd;
    bit          we0;
    bit          we1;
    bit          last_d;
    int          gcyc;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] idin;
    logic [15:0] ddin;
  } mdl_t;

  mdl_t m [2];

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.active = 1'b0; r.port_d = 1'b0; r.rd = 1'b0; r.we0 = 1'b0; r.we1 = 1'b0;
    r.last_d = 1'b0; r.gcyc = 0; r.addr = '0; r.wdata = '0; r.idin = '0; r.ddin = '0;
    return r;
  endfunction

  task automatic step(input int id, input int w, input bit fair, input logic rst,
                      input logic [15:0] iaddr, input logic ioe, input logic [15:0] daddr,
                      input logic doe, input logic dwe0, input logic dwe1, input logic [15:0] ddout,
                      input logic [15:0] maddr, input logic moe, input logic mwe0, input logic mwe1,
                      input logic [15:0] mwdata, input logic [15:0] idin, input logic i_ready,
                      input logic [15:0] ddin, input logic d_ready, input logic [15:0] rdv);
    bit fin, gd;
    logic [15:0] e_maddr, e_mwdata, e_idin, e_ddin;
    logic e_moe, e_mwe0, e_mwe1, e_ir, e_dr;
    string p;
    p = (id == 0) ? "A" : "B";
    fin = m[id].active && ((cyc - m[id].gcyc) == (w + 1));
    e_maddr = '0; e_mwdata = '0; e_idin = '0; e_ddin = '0;
    e_moe = 1'b0; e_mwe0 = 1'b0; e_mwe1 = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
    if (rst) begin
      e_idin = m[id].idin;
      e_ddin = m[id].ddin;
      if (m[id].active) begin
        e_maddr  = m[id].addr;
        e_moe    = m[id].rd;
        e_mwe0   = m[id].we0 && fin;
        e_mwe1   = m[id].we1 && fin;
        e_mwdata = m[id].port_d ? m[id].wdata : 16'h0000;
        e_ir     = !m[id].port_d && fin;
        e_dr     = m[id].port_d && fin;
      end
    end
    chk({p, ".maddr"},   32'(maddr),   32'(e_maddr));
    chk({p, ".moe"},     32'(moe),     32'(e_moe));
    chk({p, ".mwe0"},    32'(mwe0),    32'(e_mwe0));
    chk({p, ".mwe1"},    32'(mwe1),    32'(e_mwe1));
    chk({p, ".mwdata"},  32'(mwdata),  32'(e_mwdata));
    chk({p, ".idin"},    32'(idin),    32'(e_idin));
    chk({p, ".ddin"},    32'(ddin),    32'(e_ddin));
    chk({p, ".i_ready"}, 32'(i_ready), 32'(e_ir));
    chk({p, ".d_ready"}, 32'(d_ready), 32'(e_dr));
    if (!rst) begin
      m[id] = mdl_reset();
    end else if (m[id].active) begin
      if (fin) begin
        if (m[id].rd) begin
          if (m[id].port_d) m[id].ddin = rdv;
          else              m[id].idin = rdv;
        end
        m[id].active = 1'b0;
      end
    end else if (doe || dwe0 || dwe1 || ioe) begin
      gd = (doe || dwe0 || dwe1) && !(ioe && fair && m[id].last_d);
      m[id].active = 1'b1;
      m[id].gcyc   = cyc;
      m[id].port_d = gd;
      m[id].last_d = gd;
      m[id].addr   = gd ? daddr : iaddr;
      m[id].wdata  = gd ? ddout : 16'h0000;
      m[id].we0    = gd && dwe0;
      m[id].we1    = gd && dwe1;
      m[id].rd     = gd ? !(dwe0 || dwe1) : 1'b1;
    end
  endtask

  // Ready-pulse log (1 = fetch, 2 = data) and write-strobe counts.
  int rq_a[$], rc_a[$], rq_b[$], rc_b[$];
  int nw0_a = 0, nw1_a = 0, nw0_b = 0, nw1_b = 0;

  always @(negedge clk) begin
    step(0, 1, 1'b1, rst_a, bus_a.iaddr, bus_a.ioe, bus_a.daddr, bus_a.doe, bus_a.dwe0, bus_a.dwe1,
         bus_a.ddout, bus_a.maddr, bus_a.moe, bus_a.mwe0, bus_a.mwe1, bus_a.mwdata, bus_a.idin,
         bus_a.i_ready, bus_a.ddin, bus_a.d_ready,
         {mem_a[{m[0].addr[15:1], 1'b0}], mem_a[{m[0].addr[15:1], 1'b1}]});
    step(1, 0, 1'b0, rst_b, bus_b.iaddr, bus_b.ioe, bus_b.daddr, bus_b.doe, bus_b.dwe0, bus_b.dwe1,
         bus_b.ddout, bus_b.maddr, bus_b.moe, bus_b.mwe0, bus_b.mwe1, bus_b.mwdata, bus_b.idin,
         bus_b.i_ready, bus_b.ddin, bus_b.d_ready,
         {mem_b[{m[1].addr[15:1], 1'b0}], mem_b[{m[1].addr[15:1], 1'b1}]});
    if (bus_a.i_ready) begin rq_a.push_back(1); rc_a.push_back(cyc); end
    if (bus_a.d_ready) begin rq_a.push_back(2); rc_a.push_back(cyc); end
    if (bus_b.i_ready) begin rq_b.push_back(1); rc_b.push_back(cyc); end
    if (bus_b.d_ready) begin rq_b.push_back(2); rc_b.push_back(cyc); end
    if (bus_a.mwe0) nw0_a++;
    if (bus_a.mwe1) nw1_a++;
    if (bus_b.mwe0) nw0_b++;
    if (bus_b.mwe1) nw1_b++;
  end

  task automatic drive(input int id, input logic [15:0] iaddr, input logic ioe, input logic [15:0] daddr,
                       input logic doe, input logic dwe0, input logic dwe1, input logic [15:0] ddout);
    if (id == 0) begin
      bus_a.iaddr = iaddr; bus_a.ioe = ioe; bus_a.daddr = daddr;
      bus_a.doe = doe; bus_a.dwe0 = dwe0; bus_a.dwe1 = dwe1; bus_a.ddout = ddout;
    end else begin
      bus_b.iaddr = iaddr; bus_b.ioe = ioe; bus_b.daddr = daddr;
      bus_b.doe = doe; bus_b.dwe0 = dwe0; bus_b.dwe1 = dwe1; bus_b.ddout = ddout;
    end
  endtask

  function automatic logic rdy(input int id, input bit d);
    if (id == 0) return d ? bus_a.d_ready : bus_a.i_ready;
    return d ? bus_b.d_ready : bus_b.i_ready;
  endfunction

  task automatic wait_rdy(input int id, input bit d, output int at);
    at = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rdy(id, d)) begin
        at = cyc;
        break;
      end
    end
    chk("ready_seen", 32'(at >= 0), 32'd1);
  endtask

  // Present one access, hold it until its ready pulse, then drop it; returns request-to-ready latency.
  task automatic access(input int id, input bit d, input logic [15:0] addr, input logic rd_en,
                        input logic we0, input logic we1, input logic [15:0] wd, output int lat);
    int t0, at;
    t0 = cyc;
    if (d) drive(id, 16'h0000, 1'b0, addr, rd_en, we0, we1, wd);
    else   drive(id, addr, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    wait_rdy(id, d, at);
    @(posedge clk); #1;
    drive(id, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    lat = at - t0;
  endtask

  task automatic wait_pulses(input int id, input int want, output int got);
    got = 0;
    for (int n = 0; n < 60 && got < want; n++) begin
      @(negedge clk);
      if (rdy(id, 1'b0) || rdy(id, 1'b1)) got++;
    end
  endtask

  initial begin
    int lat, got, base, at;
    rst_a = 1'b0; rst_b = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    drive(0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 14; k++) begin
      pre_addr = PA[k]; pre_data = PD[k]; pre_we = 1'b1;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    chk("A.reset_maddr", 32'(bus_a.maddr), 32'h0);
    chk("A.reset_idin", 32'(bus_a.idin), 32'h0);
    @(posedge clk); #1;
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk); #1;

    // Fetch with one wait state.
    access(0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, lat);
    chk("A.fetch_latency", 32'(lat), 32'd2);
    chk("A.idin_0010", 32'(bus_a.idin), 32'h1234);
    repeat (3) @(posedge clk);
    #1;
    chk("A.idin_held", 32'(bus_a.idin), 32'h1234);

    // Data read at an odd address returns the aligned word.
    access(0, 1'b1, 16'h0021, 1'b1, 1'b0, 1'b0, 16'h0000, lat);
    chk("A.dread_latency", 32'(lat), 32'd2);
    chk("A.ddin_0021", 32'(bus_a.ddin), 32'hA55A);

    // Low-byte-only write.
    access(0, 1'b1, 16'hC001, 1'b0, 1'b0, 1'b1, 16'hABCD, lat);
    chk("A.mem_C001", 32'(mem_a[16'hC001]), 32'hCD);
    chk("A.mem_C000", 32'(mem_a[16'hC000]), 32'h77);
    chk("A.ddin_after_write", 32'(bus_a.ddin), 32'hA55A);

    // Address 0xFFFF reads bytes 0xFFFE/0xFFFF.
    access(0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, lat);
    chk("A.idin_FFFF", 32'(bus_a.idin), 32'h5C3E);

    // Fair arbitration with both ports held; last grant was a fetch.
    base = rq_a.size();
    drive(0, 16'h0040, 1'b1, 16'h0042, 1'b1, 1'b0, 1'b0, 16'h0000);
    wait_pulses(0, 4, got);
    @(posedge clk); #1;
    drive(0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("A.fair_pulses", 32'(got), 32'd4);
    chk("A.fair_order0", 32'(rq_a[base]),     32'd2);
    chk("A.fair_order1", 32'(rq_a[base + 1]), 32'd1);
    chk("A.fair_order2", 32'(rq_a[base + 2]), 32'd2);
    chk("A.fair_order3", 32'(rq_a[base + 3]), 32'd1);
    chk("A.fair_gap1", 32'(rc_a[base + 1] - rc_a[base]),     32'd3);
    chk("A.fair_gap3", 32'(rc_a[base + 3] - rc_a[base + 2]), 32'd3);
    chk("A.fair_idin", 32'(bus_a.idin), 32'hDEAD);
    chk("A.fair_ddin", 32'(bus_a.ddin), 32'hBEEF);

    // Reset during the first cycle of a two-byte write.
    drive(0, 16'h0000, 1'b0, 16'hC000, 1'b0, 1'b1, 1'b1, 16'h1357);
    @(posedge clk); #3;
    rst_a = 1'b0;
    drive(0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("A.rst_maddr", 32'(bus_a.maddr), 32'h0);
    chk("A.rst_mwe", 32'({bus_a.mwe0, bus_a.mwe1}), 32'h0);
    chk("A.rst_mwdata", 32'(bus_a.mwdata), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    chk("A.rst_mem_C000", 32'(mem_a[16'hC000]), 32'h77);
    chk("A.rst_mem_C001", 32'(mem_a[16'hC001]), 32'hCD);
    access(0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, lat);
    chk("A.post_rst_latency", 32'(lat), 32'd2);
    chk("A.post_rst_idin", 32'(bus_a.idin), 32'h1234);

    // Zero wait states: read+write request acts as a high-byte write.
    access(1, 1'b1, 16'h0200, 1'b1, 1'b1, 1'b0, 16'h5500, lat);
    chk("B.write_latency", 32'(lat), 32'd1);
    chk("B.mem_0200", 32'(mem_b[16'h0200]), 32'h55);
    chk("B.mem_0201", 32'(mem_b[16'h0201]), 32'h66);
    chk("B.ddin_after_write", 32'(bus_b.ddin), 32'h0);

    // Data-priority arbitration starves fetch until the data request drops.
    base = rq_b.size();
    drive(1, 16'h0040, 1'b1, 16'h0042, 1'b1, 1'b0, 1'b0, 16'h0000);
    wait_pulses(1, 4, got);
    @(posedge clk); #1;
    drive(1, 16'h0040, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    wait_rdy(1, 1'b0, at);
    @(posedge clk); #1;
    drive(1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("B.prio_pulses", 32'(got), 32'd4);
    for (int k = 0; k < 4; k++) chk("B.prio_data_only", 32'(rq_b[base + k]), 32'd2);
    chk("B.prio_fetch_last", 32'(rq_b[base + 4]), 32'd1);
    chk("B.prio_gap", 32'(rc_b[base + 1] - rc_b[base]), 32'd2);
    chk("B.prio_idin", 32'(bus_b.idin), 32'hDEAD);
    chk("B.prio_ddin", 32'(bus_b.ddin), 32'hBEEF);

    repeat (3) @(posedge clk);
    #1;
    chk("A.mwe0_pulses", 32'(nw0_a), 32'd0);
    chk("A.mwe1_pulses", 32'(nw1_a), 32'd1);
    chk("B.mwe0_pulses", 32'(nw0_b), 32'd1);
    chk("B.mwe1_pulses", 32'(nw1_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
